// File: rtl/uart_prot_pkg.sv
// Shared constants for the UART protocol configuration bank: register map,
// IRQ bit positions, parity encodings and protocol TX byte selects.
package uart_prot_pkg;

  localparam logic [4:0] ADDR_CTRL       = 5'd0;
  localparam logic [4:0] ADDR_SLAVE_ADDR = 5'd1;
  localparam logic [4:0] ADDR_SELF_ADDR  = 5'd2;
  localparam logic [4:0] ADDR_STOP_FRAME = 5'd3;
  localparam logic [4:0] ADDR_BAUD_LO    = 5'd4;
  localparam logic [4:0] ADDR_BAUD_HI    = 5'd5;
  localparam logic [4:0] ADDR_TX_DATA    = 5'd6;
  localparam logic [4:0] ADDR_RX_DATA    = 5'd7;
  localparam logic [4:0] ADDR_PARITY     = 5'd8;
  localparam logic [4:0] ADDR_STOP       = 5'd9;
  localparam logic [4:0] ADDR_STATUS     = 5'd10;
  localparam logic [4:0] ADDR_TX_LEVEL   = 5'd11;
  localparam logic [4:0] ADDR_RX_LEVEL   = 5'd12;
  localparam logic [4:0] ADDR_IRQ_EN     = 5'd13;
  localparam logic [4:0] ADDR_IRQ_STAT   = 5'd14;
  localparam logic [4:0] ADDR_RX_THRESH  = 5'd15;

  localparam int unsigned IRQ_TX_EMPTY = 0;
  localparam int unsigned IRQ_RX_THR   = 1;
  localparam int unsigned IRQ_TX_OVF   = 2;
  localparam int unsigned IRQ_RX_OVF   = 3;
  localparam int unsigned IRQ_RX_UDF   = 4;
  localparam int unsigned IRQ_W        = 5;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_RSVD = 2'b10;
  localparam logic [1:0] PAR_EVEN = 2'b11;

  localparam logic [1:0] TX_SEL_SLAVE = 2'd0;
  localparam logic [1:0] TX_SEL_FIFO  = 2'd1;
  localparam logic [1:0] TX_SEL_STOP  = 2'd2;
  localparam logic [1:0] TX_SEL_ZERO  = 2'd3;

endpackage

// File: rtl/uart_cfg_fifo.sv
// Show-ahead FIFO with synchronous flush, occupancy counter and overflow
// event; full/empty are derived from the level counter.
module uart_cfg_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     glb_clk,
  input  logic                     glb_rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  // A push into a full FIFO is accepted when a pop frees the slot the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || pop) && !flush;
  assign ovf     = push && full && !pop && !flush;

  always_ff @(posedge glb_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/uart_prot_cfg_bank.sv
// UART protocol configuration bank: user-bus register file, TX/RX byte FIFOs,
// sticky error flags and a maskable registered interrupt.
module uart_prot_cfg_bank
  import uart_prot_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BAUD_W     = 16
) (
  input  logic              glb_clk,
  input  logic              glb_rst,
  input  logic [4:0]        usr_addr,
  input  logic [DATA_W-1:0] usr_wdata,
  input  logic              usr_wr,
  input  logic              usr_rd,
  output logic [DATA_W-1:0] usr_rdata,
  output logic              usr_rvalid,
  input  logic [1:0]        prot_tx_sel,
  output logic [DATA_W-1:0] prot_tx_data,
  input  logic              prot_tx_pop,
  input  logic              prot_rx_push,
  input  logic [DATA_W-1:0] prot_rx_data,
  input  logic              prot_tx_done,
  input  logic              prot_rx_done,
  output logic              cfg_tx_en,
  output logic              cfg_rx_en,
  output logic [1:0]        cfg_parity,
  output logic              cfg_stop,
  output logic [BAUD_W-1:0] cfg_baud_cmp,
  output logic [DATA_W-1:0] cfg_self_addr,
  output logic              tx_empty,
  output logic              rx_empty,
  output logic              irq
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0]   slave_addr, stop_frame, rx_thresh;
  logic [IRQ_W-1:0]    irq_en, irq_stat, w1c;
  logic                tx_ovf_q, rx_ovf_q, rx_udf_q;
  logic                tx_push, tx_flush, tx_full, tx_ovf_ev;
  logic                rx_pop, rx_flush, rx_full, rx_ovf_ev, rx_udf_ev, rx_thr;
  logic [DATA_W-1:0]   tx_head, rx_head, rd_mux;
  logic [LVL_W-1:0]    tx_level, rx_level;
  logic                ctrl_wr;
  logic [2*DATA_W-1:0] baud_ext, baud_nxt;

  assign ctrl_wr   = usr_wr && (usr_addr == ADDR_CTRL);
  assign tx_flush  = ctrl_wr && usr_wdata[2];
  assign rx_flush  = ctrl_wr && usr_wdata[3];
  assign tx_push   = usr_wr && (usr_addr == ADDR_TX_DATA);
  assign rx_pop    = usr_rd && (usr_addr == ADDR_RX_DATA);
  assign rx_udf_ev = rx_pop && rx_empty && !rx_flush;

  uart_cfg_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .glb_clk(glb_clk), .glb_rst(glb_rst), .flush(tx_flush), .push(tx_push),
    .pop(prot_tx_pop), .wdata(usr_wdata), .head(tx_head), .level(tx_level),
    .full(tx_full), .empty(tx_empty), .ovf(tx_ovf_ev)
  );

  uart_cfg_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .glb_clk(glb_clk), .glb_rst(glb_rst), .flush(rx_flush), .push(prot_rx_push),
    .pop(rx_pop), .wdata(prot_rx_data), .head(rx_head), .level(rx_level),
    .full(rx_full), .empty(rx_empty), .ovf(rx_ovf_ev)
  );

  assign rx_thr = (rx_thresh != '0) && (DATA_W'(rx_level) >= rx_thresh);

  always_comb begin
    irq_stat               = '0;
    irq_stat[IRQ_TX_EMPTY] = tx_empty;
    irq_stat[IRQ_RX_THR]   = rx_thr;
    irq_stat[IRQ_TX_OVF]   = tx_ovf_q;
    irq_stat[IRQ_RX_OVF]   = rx_ovf_q;
    irq_stat[IRQ_RX_UDF]   = rx_udf_q;
  end

  assign w1c = (usr_wr && (usr_addr == ADDR_IRQ_STAT)) ? usr_wdata[IRQ_W-1:0] : '0;

  // Baud is handled as a 2*DATA_W image so LO/HI writes and reads are plain slices.
  always_comb begin
    baud_ext = (2*DATA_W)'(cfg_baud_cmp);
    baud_nxt = baud_ext;
    if (usr_addr == ADDR_BAUD_LO) baud_nxt[DATA_W-1:0]        = usr_wdata;
    if (usr_addr == ADDR_BAUD_HI) baud_nxt[2*DATA_W-1:DATA_W] = usr_wdata;
  end

  always_comb begin
    case (prot_tx_sel)
      TX_SEL_SLAVE: prot_tx_data = slave_addr;
      TX_SEL_FIFO:  prot_tx_data = tx_head;
      TX_SEL_STOP:  prot_tx_data = stop_frame;
      TX_SEL_ZERO:  prot_tx_data = '0;
      default:      prot_tx_data = '0;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (usr_addr)
      ADDR_CTRL:       rd_mux = DATA_W'({cfg_rx_en, cfg_tx_en});
      ADDR_SLAVE_ADDR: rd_mux = slave_addr;
      ADDR_SELF_ADDR:  rd_mux = cfg_self_addr;
      ADDR_STOP_FRAME: rd_mux = stop_frame;
      ADDR_BAUD_LO:    rd_mux = baud_ext[DATA_W-1:0];
      ADDR_BAUD_HI:    rd_mux = baud_ext[2*DATA_W-1:DATA_W];
      ADDR_RX_DATA:    rd_mux = rx_empty ? '0 : rx_head;
      ADDR_PARITY:     rd_mux = DATA_W'(cfg_parity);
      ADDR_STOP:       rd_mux = DATA_W'(cfg_stop);
      ADDR_STATUS:     rd_mux = DATA_W'({rx_full, rx_empty, tx_full, tx_empty});
      ADDR_TX_LEVEL:   rd_mux = DATA_W'(tx_level);
      ADDR_RX_LEVEL:   rd_mux = DATA_W'(rx_level);
      ADDR_IRQ_EN:     rd_mux = DATA_W'(irq_en);
      ADDR_IRQ_STAT:   rd_mux = DATA_W'(irq_stat);
      ADDR_RX_THRESH:  rd_mux = rx_thresh;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      cfg_tx_en     <= 1'b0;
      cfg_rx_en     <= 1'b0;
      cfg_parity    <= PAR_NONE;
      cfg_stop      <= 1'b0;
      cfg_baud_cmp  <= '0;
      cfg_self_addr <= '0;
      slave_addr    <= '0;
      stop_frame    <= '0;
      rx_thresh     <= '0;
      irq_en        <= '0;
      tx_ovf_q      <= 1'b0;
      rx_ovf_q      <= 1'b0;
      rx_udf_q      <= 1'b0;
      irq           <= 1'b0;
      usr_rdata     <= '0;
      usr_rvalid    <= 1'b0;
    end else begin
      if (prot_tx_done)                 cfg_tx_en <= 1'b0;
      else if (ctrl_wr && usr_wdata[0]) cfg_tx_en <= 1'b1;
      if (prot_rx_done)                 cfg_rx_en <= 1'b0;
      else if (ctrl_wr && usr_wdata[1]) cfg_rx_en <= 1'b1;

      if (usr_wr) begin
        case (usr_addr)
          ADDR_SLAVE_ADDR: slave_addr    <= usr_wdata;
          ADDR_SELF_ADDR:  cfg_self_addr <= usr_wdata;
          ADDR_STOP_FRAME: stop_frame    <= usr_wdata;
          ADDR_BAUD_LO,
          ADDR_BAUD_HI:    cfg_baud_cmp  <= baud_nxt[BAUD_W-1:0];
          ADDR_PARITY:     cfg_parity    <= (usr_wdata[1:0] == PAR_RSVD) ? PAR_NONE : usr_wdata[1:0];
          ADDR_STOP:       cfg_stop      <= usr_wdata[0];
          ADDR_IRQ_EN:     irq_en        <= usr_wdata[IRQ_W-1:0];
          ADDR_RX_THRESH:  rx_thresh     <= usr_wdata;
          default: ;
        endcase
      end

      tx_ovf_q <= (tx_ovf_q && !w1c[IRQ_TX_OVF]) || tx_ovf_ev;
      rx_ovf_q <= (rx_ovf_q && !w1c[IRQ_RX_OVF]) || rx_ovf_ev;
      rx_udf_q <= (rx_udf_q && !w1c[IRQ_RX_UDF]) || rx_udf_ev;
      irq      <= |(irq_stat & irq_en);

      usr_rvalid <= usr_rd;
      if (usr_rd) usr_rdata <= rd_mux;
    end
  end

endmodule
